// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S sample sequencer and its helpers.
package i2s_pkg;

    localparam int SAMPLE_W        = 24;
    localparam int LAT_MAX_DEFAULT = 64;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    // Round-robin pick: with both slots pending, serve the channel not served last.
    function automatic chan_t rr_pick(input logic v_l, input logic v_r, input chan_t last);
        if (v_l && v_r) begin
            return (last == CH_LEFT) ? CH_RIGHT : CH_LEFT;
        end else if (v_l) begin
            return CH_LEFT;
        end else begin
            return CH_RIGHT;
        end
    endfunction

endpackage

// File: rtl/i2s_lrclk_edge.sv
// Registers the (already mclk-synchronous) LRCLK and flags its edges for one cycle.
module i2s_lrclk_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_lrclk,
    output logic o_fall,
    output logic o_rise
);

    logic r_lrclk_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lrclk_q <= 1'b0;
        end else begin
            r_lrclk_q <= i_lrclk;
        end
    end

    assign o_fall = r_lrclk_q & ~i_lrclk;
    assign o_rise = ~r_lrclk_q & i_lrclk;

endmodule

// File: rtl/i2s_sample_sequencer.sv
// Sequences receiver samples through a shared effects core (or bypass) and
// double-buffers the results into one stable left/right pair per LRCLK frame.
module i2s_sample_sequencer
    import i2s_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int LAT_MAX = LAT_MAX_DEFAULT
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              enable,
    input  logic              bypass,
    input  logic              clear_flags,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_chan,
    input  logic              lrclk,
    output logic              fx_req_valid,
    input  logic              fx_req_ready,
    output logic [DATA_W-1:0] fx_req_data,
    output logic              fx_req_chan,
    input  logic              fx_rsp_valid,
    input  logic [DATA_W-1:0] fx_rsp_data,
    input  logic              fx_rsp_chan,
    output logic [DATA_W-1:0] tx_left,
    output logic [DATA_W-1:0] tx_right,
    output logic              tx_load,
    output logic              overrun,
    output logic              timeout
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    chan_t             r_sel;
    chan_t             r_last_served;
    chan_t             w_pick;
    logic [7:0]        r_cnt;
    logic [DATA_W-1:0] r_req_data;

    // Index 0 = left, 1 = right.
    logic [DATA_W-1:0] r_pend [2];
    logic [1:0]        r_pend_v;
    logic [DATA_W-1:0] r_stg  [2];

    logic [DATA_W-1:0] r_tx_l;
    logic [DATA_W-1:0] r_tx_r;
    logic              r_tx_load;
    logic              r_overrun;
    logic              r_timeout;

    logic              w_lrclk_fall;
    logic              w_idle;
    logic              w_idle_clr;
    logic              w_bypass_wr;
    logic              w_rsp_hit;
    logic              w_cnt_done;
    logic              w_fx_done;
    logic [1:0]        w_rx_oh;
    logic [1:0]        w_sel_oh;
    logic [1:0]        w_pend_wr;
    logic [1:0]        w_take;
    logic [1:0]        w_stg_wr;
    logic [DATA_W-1:0] w_stg_din;
    logic              w_ovr_set;
    logic              w_to_set;

    i2s_lrclk_edge u_lrclk_edge (
        .i_clk   (mclk),
        .i_rst_n (rst),
        .i_lrclk (lrclk),
        .o_fall  (w_lrclk_fall),
        .o_rise  ()
    );

    assign w_idle      = (r_state == IDLE);
    assign w_idle_clr  = w_idle & ~enable;
    assign w_bypass_wr = w_idle & enable & bypass & rx_valid;
    assign w_rx_oh     = {rx_chan, ~rx_chan};
    assign w_sel_oh    = {r_sel == CH_RIGHT, r_sel == CH_LEFT};
    assign w_pick      = rr_pick(r_pend_v[0], r_pend_v[1], r_last_served);

    // Bypass in IDLE steers rx straight to staging; otherwise it lands in a pending slot.
    assign w_pend_wr   = (rx_valid && !(w_idle && (bypass || !enable))) ? w_rx_oh : 2'b00;
    assign w_take      = ((r_state == ISSUE) && fx_req_ready) ? w_sel_oh : 2'b00;

    assign w_rsp_hit   = (r_state == WAIT) && fx_rsp_valid && (chan_t'(fx_rsp_chan) == r_sel);
    assign w_cnt_done  = (r_state == WAIT) && (r_cnt == 8'(LAT_MAX - 1));
    assign w_fx_done   = w_rsp_hit | w_cnt_done;

    // A late core keeps the unprocessed sample; enable=0 during WAIT drops the result.
    assign w_stg_din   = w_bypass_wr ? rx_data : (w_rsp_hit ? fx_rsp_data : r_req_data);
    assign w_stg_wr    = (w_bypass_wr ? w_rx_oh : 2'b00)
                       | ((w_fx_done && enable) ? w_sel_oh : 2'b00);

    // A slot reloaded in the same cycle it is consumed is not an overrun.
    assign w_ovr_set   = |(w_pend_wr & r_pend_v & ~w_take);
    assign w_to_set    = w_cnt_done & ~w_rsp_hit;

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable && !bypass && (|r_pend_v)) w_state_nxt = ISSUE;
            ISSUE:   if (fx_req_ready) w_state_nxt = WAIT;
            WAIT:    if (w_fx_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_sel         <= CH_LEFT;
            r_last_served <= CH_RIGHT;
            r_req_data    <= '0;
            r_cnt         <= '0;
        end else begin
            if (w_idle && (w_state_nxt == ISSUE)) begin
                r_sel         <= w_pick;
                r_last_served <= w_pick;
                r_req_data    <= r_pend[w_pick];
            end
            if (r_state == ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                r_pend[i] <= '0;
                r_stg[i]  <= '0;
            end
            r_pend_v <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_idle_clr) begin
                    r_pend[i]   <= '0;
                    r_pend_v[i] <= 1'b0;
                    r_stg[i]    <= '0;
                end else begin
                    if (w_pend_wr[i]) begin
                        r_pend[i]   <= rx_data;
                        r_pend_v[i] <= 1'b1;
                    end else if (w_take[i]) begin
                        r_pend_v[i] <= 1'b0;
                    end
                    if (w_stg_wr[i]) begin
                        r_stg[i] <= w_stg_din;
                    end
                end
            end
        end
    end

    // Frame commit copies staging as it stood before this edge.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_tx_l    <= '0;
            r_tx_r    <= '0;
            r_tx_load <= 1'b0;
        end else begin
            r_tx_load <= w_lrclk_fall;
            if (w_lrclk_fall) begin
                r_tx_l <= r_stg[0];
                r_tx_r <= r_stg[1];
            end
        end
    end

    // Set beats a simultaneous clear.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clear_flags) begin
                r_overrun <= 1'b0;
            end
            if (w_to_set) begin
                r_timeout <= 1'b1;
            end else if (clear_flags) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign fx_req_valid = (r_state == ISSUE);
    assign fx_req_data  = r_req_data;
    assign fx_req_chan  = r_sel;
    assign tx_left      = r_tx_l;
    assign tx_right     = r_tx_r;
    assign tx_load      = r_tx_load;
    assign overrun      = r_overrun;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_i2s_sample_sequencer.sv
// Directed bench for i2s_sample_sequencer with a small behavioural effects core.
module tb_i2s_sample_sequencer;

    localparam int DW = 24;

    logic          mclk = 1'b0;
    logic          rst;
    logic          enable;
    logic          bypass;
    logic          clear_flags;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_chan;
    logic          lrclk;
    logic          fx_req_valid;
    logic          fx_req_ready;
    logic [DW-1:0] fx_req_data;
    logic          fx_req_chan;
    logic          fx_rsp_valid;
    logic [DW-1:0] fx_rsp_data;
    logic          fx_rsp_chan;
    logic [DW-1:0] tx_left;
    logic [DW-1:0] tx_right;
    logic          tx_load;
    logic          overrun;
    logic          timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Effects-core model controls.
    logic          fx_respond;
    int            fx_lat;
    logic [DW-1:0] fx_add;
    logic [DW-1:0] cap_data;
    logic          cap_chan;
    int            rsp_cnt;

    always #5 mclk = ~mclk;

    i2s_sample_sequencer #(.DATA_W(24), .LAT_MAX(64)) dut (
        .mclk         (mclk),
        .rst          (rst),
        .enable       (enable),
        .bypass       (bypass),
        .clear_flags  (clear_flags),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_chan      (rx_chan),
        .lrclk        (lrclk),
        .fx_req_valid (fx_req_valid),
        .fx_req_ready (fx_req_ready),
        .fx_req_data  (fx_req_data),
        .fx_req_chan  (fx_req_chan),
        .fx_rsp_valid (fx_rsp_valid),
        .fx_rsp_data  (fx_rsp_data),
        .fx_rsp_chan  (fx_rsp_chan),
        .tx_left      (tx_left),
        .tx_right     (tx_right),
        .tx_load      (tx_load),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic send_rx(input logic ch, input logic [DW-1:0] d);
        rx_valid = 1'b1;
        rx_chan  = ch;
        rx_data  = d;
        tick(1);
        rx_valid = 1'b0;
    endtask

    // Polls (bounded) for the next request, then checks its channel and data.
    task automatic wait_req(input string tag, input logic ch, input logic [DW-1:0] d);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (fx_req_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check_eq({tag, "_chan"}, {31'd0, fx_req_chan}, {31'd0, ch});
            check_eq({tag, "_data"}, {8'd0, fx_req_data}, {8'd0, d});
        end
    endtask

    // One LRCLK period ending in a falling edge; tx_load must pulse the cycle after.
    task automatic frame(input string tag);
        lrclk = 1'b1;
        tick(2);
        lrclk = 1'b0;
        tick(1);
        check_eq({tag, "_load"}, {31'd0, tx_load}, 32'd1);
        tick(1);
        check_eq({tag, "_load_end"}, {31'd0, tx_load}, 32'd0);
    endtask

    initial begin
        fx_rsp_valid = 1'b0;
        fx_rsp_data  = '0;
        fx_rsp_chan  = 1'b0;
        rsp_cnt      = 0;
        cap_data     = '0;
        cap_chan     = 1'b0;
        forever begin
            @(negedge mclk);
            fx_rsp_valid = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    fx_rsp_valid = 1'b1;
                    fx_rsp_data  = cap_data + fx_add;
                    fx_rsp_chan  = cap_chan;
                end
            end
            if (fx_respond && fx_req_valid && fx_req_ready) begin
                cap_data = fx_req_data;
                cap_chan = fx_req_chan;
                rsp_cnt  = fx_lat;
            end
        end
    end

    initial begin
        bit any_req;
        rst          = 1'b0;
        enable       = 1'b1;
        bypass       = 1'b0;
        clear_flags  = 1'b0;
        rx_data      = '0;
        rx_valid     = 1'b0;
        rx_chan      = 1'b0;
        lrclk        = 1'b0;
        fx_req_ready = 1'b1;
        fx_respond   = 1'b1;
        fx_lat       = 3;
        fx_add       = 24'd1;

        tick(2);
        check_eq("rst_req_valid", {31'd0, fx_req_valid}, 32'd0);
        check_eq("rst_tx_left",   {8'd0, tx_left}, 32'd0);
        check_eq("rst_tx_right",  {8'd0, tx_right}, 32'd0);
        check_eq("rst_tx_load",   {31'd0, tx_load}, 32'd0);
        check_eq("rst_overrun",   {31'd0, overrun}, 32'd0);
        check_eq("rst_timeout",   {31'd0, timeout}, 32'd0);
        rst = 1'b1;
        tick(1);

        // Single left sample through a +1 core with 3-cycle latency.
        send_rx(1'b0, 24'd50321);
        check_eq("t1_req_t1", {31'd0, fx_req_valid}, 32'd0);
        tick(1);
        check_eq("t1_req_t2",  {31'd0, fx_req_valid}, 32'd1);
        check_eq("t1_req_chan", {31'd0, fx_req_chan}, 32'd0);
        check_eq("t1_req_data", {8'd0, fx_req_data}, 32'd50321);
        tick(1);
        check_eq("t1_req_drop", {31'd0, fx_req_valid}, 32'd0);
        tick(8);
        frame("t1");
        check_eq("t1_tx_left",  {8'd0, tx_left}, 32'd50322);
        check_eq("t1_tx_right", {8'd0, tx_right}, 32'd0);

        // Right primer leaves last_served=right; both slots then fill during WAIT.
        fx_add = 24'd0;
        fx_lat = 8;
        send_rx(1'b1, 24'd777);
        tick(2);
        send_rx(1'b0, 24'd16777215);
        send_rx(1'b1, 24'd0);
        fx_lat = 3;
        wait_req("t2_first", 1'b0, 24'd16777215);
        wait_req("t2_second", 1'b1, 24'd0);
        tick(10);
        frame("t2");
        check_eq("t2_tx_left",  {8'd0, tx_left}, 32'd16777215);
        check_eq("t2_tx_right", {8'd0, tx_right}, 32'd0);
        check_eq("t2_overrun",  {31'd0, overrun}, 32'd0);

        // Overrun: two lefts land while a right request is stalled.
        fx_req_ready = 1'b0;
        send_rx(1'b1, 24'd100);
        tick(2);
        send_rx(1'b0, 24'd200);
        check_eq("t3_no_ovr_yet", {31'd0, overrun}, 32'd0);
        send_rx(1'b0, 24'd300);
        check_eq("t3_overrun", {31'd0, overrun}, 32'd1);
        fx_req_ready = 1'b1;
        wait_req("t3_left", 1'b0, 24'd300);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        check_eq("t3_cleared", {31'd0, overrun}, 32'd0);
        tick(10);
        frame("t3");
        check_eq("t3_tx_left",  {8'd0, tx_left}, 32'd300);
        check_eq("t3_tx_right", {8'd0, tx_right}, 32'd100);

        // Silent core: timeout after 64 WAIT cycles, raw sample forwarded.
        fx_respond = 1'b0;
        send_rx(1'b0, 24'd34245);
        wait_req("t4_req", 1'b0, 24'd34245);
        tick(64);
        check_eq("t4_not_yet", {31'd0, timeout}, 32'd0);
        tick(1);
        check_eq("t4_timeout", {31'd0, timeout}, 32'd1);
        check_eq("t4_idle_req", {31'd0, fx_req_valid}, 32'd0);
        frame("t4");
        check_eq("t4_tx_left", {8'd0, tx_left}, 32'd34245);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        check_eq("t4_cleared", {31'd0, timeout}, 32'd0);
        fx_respond = 1'b1;

        // Bypass: straight to staging, core untouched.
        bypass = 1'b1;
        tick(1);
        any_req = 1'b0;
        send_rx(1'b1, 24'd34245);
        for (int i = 0; i < 6; i++) begin
            any_req |= fx_req_valid;
            tick(1);
        end
        check_eq("t5_no_req", {31'd0, any_req}, 32'd0);
        frame("t5");
        check_eq("t5_tx_right", {8'd0, tx_right}, 32'd34245);
        check_eq("t5_tx_left",  {8'd0, tx_left}, 32'd34245);
        bypass = 1'b0;
        tick(1);

        // Reset in the middle of a stalled request.
        fx_req_ready = 1'b0;
        send_rx(1'b0, 24'd4242);
        tick(1);
        check_eq("t6_req_before", {31'd0, fx_req_valid}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("t6_req_valid", {31'd0, fx_req_valid}, 32'd0);
        check_eq("t6_req_data",  {8'd0, fx_req_data}, 32'd0);
        check_eq("t6_tx_left",   {8'd0, tx_left}, 32'd0);
        check_eq("t6_tx_right",  {8'd0, tx_right}, 32'd0);
        check_eq("t6_tx_load",   {31'd0, tx_load}, 32'd0);
        check_eq("t6_flags",     {30'd0, overrun, timeout}, 32'd0);
        tick(1);
        rst = 1'b1;
        fx_req_ready = 1'b1;
        fx_add = 24'd1;
        tick(1);
        send_rx(1'b0, 24'd9);
        wait_req("t6_after", 1'b0, 24'd9);
        tick(10);
        frame("t6");
        check_eq("t6_final_left",  {8'd0, tx_left}, 32'd10);
        check_eq("t6_final_right", {8'd0, tx_right}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
